sar_compare_search: RTL and testbench

// - Successive-approximation search engine. Upstream of, and closed-loop with, the 4-bit magnitude comparator.
// - Drives the comparator's B operand (guess) and reads back Eq/Gt/Lt.
// - Recovers the unknown A operand in at most WIDTH probes.
// - Used as the sequential follow-on to the combinational comparator lab: the comparator stays combinational, this block owns all state.

---
 rtl/sar_compare_search.sv | 119 +++++++++++
 tb/tb_sar_compare_search.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_compare_search.sv
// sar_compare_search: successive-approximation search engine that drives a
// combinational magnitude comparator's B operand (guess), reads back
// eq/gt/lt and recovers the comparator's A operand in at most WIDTH probes.
// Optional feature macro: SAR_EARLY_EXIT_EN. When it is defined, an eq
// response ends the search at once.
module sar_compare_search #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         eq,
    input  logic                         gt,
    input  logic                         lt,
    output logic [WIDTH-1:0]             guess,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+1)-1:0]   steps,
    output logic                         err
);
    localparam int SW = $clog2(WIDTH+1);
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [WIDTH-1:0] guess_nxt, result_nxt, trial;
    logic [SW-1:0]   steps_nxt;
    logic            err_nxt;
    logic            flags_ok;

    // A valid comparator response has exactly one of eq/gt/lt set.
    assign flags_ok = ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
                      ({eq, gt, lt} == 3'b001);

    assign busy = (state == PROBE);
    assign done = (state == DONE);

    // State and datapath registers; reset aborts any search in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            guess  <= '0;
            result <= '0;
            steps  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            guess  <= guess_nxt;
            result <= result_nxt;
            steps  <= steps_nxt;
            err    <= err_nxt;
        end
    end

    // Next-state logic: one bit decided per PROBE cycle, pure set/clear.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        guess_nxt  = guess;
        result_nxt = result;
        steps_nxt  = steps;
        err_nxt    = err;
        trial      = guess;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = PROBE;
                    guess_nxt  = '0;
                    guess_nxt[WIDTH-1] = 1'b1;
                    k_nxt      = KW'(WIDTH-1);
                    steps_nxt  = '0;
                    err_nxt    = 1'b0;
                end
            end
            PROBE: begin
                steps_nxt = steps + SW'(1);
                if (!flags_ok) begin
                    err_nxt    = 1'b1;
                    result_nxt = '0;
                    state_nxt  = DONE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (eq) begin
                    result_nxt = guess;
                    state_nxt  = DONE;
                end
`endif
                else begin
                    // lt means A is below the trial, so this bit must be 0.
                    if (lt) trial[k] = 1'b0;
                    if (k == '0) begin
                        guess_nxt  = trial;
                        result_nxt = trial;
                        state_nxt  = DONE;
                    end else begin
                        trial[k - KW'(1)] = 1'b1;
                        guess_nxt = trial;
                        k_nxt     = k - KW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sar_compare_search.sv
// tb_sar_compare_search: directed bench for sar_compare_search with a
// behavioural comparator driven from a bench-held A and the DUT's guess.
module tb_sar_compare_search;
    localparam int WIDTH = 4;
    localparam int SW    = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             eq, gt, lt;
    logic [WIDTH-1:0] guess, result;
    logic             busy, done, err;
    logic [SW-1:0]    steps;

    logic [WIDTH-1:0] a = '0;
    logic             bad = 1'b0;

    int tests = 0;
    int fails = 0;

    // Results of the most recent search
    logic [WIDTH-1:0] glog [0:11];
    int               nprobe;
    logic [WIDTH-1:0] r_result;
    logic [SW-1:0]    r_steps;
    logic             r_err;
    logic             r_done;

    sar_compare_search #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .eq(eq), .gt(gt), .lt(lt),
        .guess(guess), .busy(busy), .done(done),
        .result(result), .steps(steps), .err(err)
    );

    always #5 clk = ~clk;

    // Comparator model; 'bad' forces the illegal eq=gt=1 response.
    always_comb begin
        if (bad) begin
            eq = 1'b1; gt = 1'b1; lt = 1'b0;
        end else begin
            eq = (a == guess);
            gt = (a > guess);
            lt = (a < guess);
        end
    end

    // Launch one search and follow it to done (bounded).
    task automatic do_search(input logic [WIDTH-1:0] a_val, input int bad_probe,
                             input int start_probe);
        a = a_val;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nprobe = 0;
        while (!done && nprobe < 12) begin
            glog[nprobe] = guess;
            bad   = (nprobe + 1 == bad_probe);
            start = (nprobe + 1 == start_probe);
            @(posedge clk); #1;
            nprobe++;
        end
        bad   = 1'b0;
        start = 1'b0;
        r_done   = done;
        r_result = result;
        r_steps  = steps;
        r_err    = err;
        tests++;
        if (r_done !== 1'b1) begin
            fails++;
            $display("FAIL search_timeout A=%0d: done=%b after %0d cycles, required 1", a_val, r_done, nprobe);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_one_cycle A=%0d: done=%b, required 0", a_val, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({guess, result, steps, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: guess=%0d result=%0d steps=%0d busy=%b done=%b err=%b, required all 0",
                     guess, result, steps, busy, done, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_a11();
        logic [WIDTH-1:0] exp_g [0:3];
        exp_g = '{4'd8, 4'd12, 4'd10, 4'd11};
        do_search(4'd11, 0, 0);
        tests++;
        if (nprobe !== 4) begin
            fails++;
            $display("FAIL a11_probes: %0d, required 4", nprobe);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (glog[i] !== exp_g[i]) begin
                fails++;
                $display("FAIL a11_guess%0d: %0d, required %0d", i, glog[i], exp_g[i]);
            end
        end
        tests++;
        if (r_result !== 4'd11 || r_steps !== 3'd4 || r_err !== 1'b0) begin
            fails++;
            $display("FAIL a11_result: result=%0d steps=%0d err=%b, required 11/4/0", r_result, r_steps, r_err);
        end
    endtask

    task automatic test_a8();
        do_search(4'd8, 0, 0);
`ifdef SAR_EARLY_EXIT_EN
        tests++;
        if (r_result !== 4'd8 || r_steps !== 3'd1 || nprobe !== 1) begin
            fails++;
            $display("FAIL a8_early: result=%0d steps=%0d probes=%0d, required 8/1/1", r_result, r_steps, nprobe);
        end
`else
        tests++;
        if (glog[0] !== 4'd8 || glog[1] !== 4'd12 || glog[2] !== 4'd10 || glog[3] !== 4'd9) begin
            fails++;
            $display("FAIL a8_guesses: %0d,%0d,%0d,%0d, required 8,12,10,9", glog[0], glog[1], glog[2], glog[3]);
        end
        tests++;
        if (r_result !== 4'd8 || r_steps !== 3'd4) begin
            fails++;
            $display("FAIL a8_result: result=%0d steps=%0d, required 8/4", r_result, r_steps);
        end
`endif
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            do_search(v[WIDTH-1:0], 0, 0);
            tests++;
            if (r_result !== v[WIDTH-1:0] || r_err !== 1'b0) begin
                fails++;
                $display("FAIL sweep_A%0d: result=%0d err=%b, required %0d/0", v, r_result, r_err, v);
            end
            if (v == 0) begin
                tests++;
                if (glog[0] !== 4'd8 || glog[1] !== 4'd4 || glog[2] !== 4'd2 || glog[3] !== 4'd1) begin
                    fails++;
                    $display("FAIL sweep_A0_guesses: %0d,%0d,%0d,%0d, required 8,4,2,1", glog[0], glog[1], glog[2], glog[3]);
                end
            end
            if (v == 15) begin
                tests++;
                if (glog[0] !== 4'd8 || glog[1] !== 4'd12 || glog[2] !== 4'd14 || glog[3] !== 4'd15) begin
                    fails++;
                    $display("FAIL sweep_A15_guesses: %0d,%0d,%0d,%0d, required 8,12,14,15", glog[0], glog[1], glog[2], glog[3]);
                end
            end
        end
    endtask

    task automatic test_flag_error();
        do_search(4'd11, 2, 0);
        tests++;
        if (r_err !== 1'b1 || r_result !== 4'd0 || nprobe !== 2 || r_steps !== 3'd2) begin
            fails++;
            $display("FAIL flag_err: err=%b result=%0d probes=%0d steps=%0d, required 1/0/2/2", r_err, r_result, nprobe, r_steps);
        end
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL flag_err_sticky: err=%b, required 1", err);
        end
        do_search(4'd11, 0, 0);
        tests++;
        if (r_err !== 1'b0 || r_result !== 4'd11) begin
            fails++;
            $display("FAIL flag_err_clear: err=%b result=%0d, required 0/11", r_err, r_result);
        end
    endtask

    task automatic test_start_ignored();
        do_search(4'd6, 0, 2);
        tests++;
        if (r_result !== 4'd6 || r_steps !== 3'd4 || nprobe !== 4) begin
            fails++;
            $display("FAIL start_in_probe: result=%0d steps=%0d probes=%0d, required 6/4/4", r_result, r_steps, nprobe);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_in_probe_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        a = 4'd13;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({guess, result, steps, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: guess=%0d result=%0d steps=%0d busy=%b done=%b err=%b, required all 0",
                     guess, result, steps, busy, done, err);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: %0d done pulses, required 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 4'd5;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 20);
        tests++;
        if (done !== 1'b1 || result !== 4'd5 || cyc !== 5) begin
            fails++;
            $display("FAIL b2b_first: done=%b result=%0d cycles=%0d, required 1/5/5", done, result, cyc);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0/0", busy, done);
        end
        a = 4'd10;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || guess !== 4'd8) begin
            fails++;
            $display("FAIL b2b_relaunch: busy=%b guess=%0d, required 1/8", busy, guess);
        end
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (done !== 1'b1 || result !== 4'd10) begin
            fails++;
            $display("FAIL b2b_second: done=%b result=%0d, required 1/10", done, result);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_a11();
        test_a8();
        test_sweep();
        test_flag_error();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
